// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding,
// the result pattern reported on a watchdog expiry, and a pointer-width helper.
package divider_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_BUSY   = 3'd2,
    ST_WAIT_RESULT = 3'd3,
    ST_DELIVER     = 3'd4
  } state_t;

  // Quotient/remainder pattern returned when the divider never answers.
  // Sliced down to the operand width at the point of use.
  localparam int                         RESULT_MAX_BITS = 64;
  localparam logic [RESULT_MAX_BITS-1:0] TIMEOUT_RESULT  = '1;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// Round-robin picker: returns the first asserted request at or after rr_ptr,
// wrapping at N_REQ. Purely combinational.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;

  // Candidate gi is the requester gi positions after rr_ptr; rr_ptr < N_REQ
  // so a single conditional subtract is enough to wrap.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [PTR_W:0] sum;
    assign sum           = {1'b0, rr_ptr} + (PTR_W+1)'(gi);
    assign cand_idx[gi]  = (sum >= (PTR_W+1)'(N_REQ)) ?
                           PTR_W'(sum - (PTR_W+1)'(N_REQ)) : sum[PTR_W-1:0];
    assign cand_hit[gi]  = req[cand_idx[gi]];
  end

  // Lowest rotated offset wins: scan from the far end so nearer hits override.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one iterative divider among N_REQ requesters with round-robin
// arbitration. Optional watchdog enabled by defining DIVIDER_ARBITER_TIMEOUT_EN.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int N_BITS         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*N_BITS-1:0] req_numerator,
  input  logic [N_REQ*N_BITS-1:0] req_denominator,
  input  logic [N_REQ-1:0]        req_numerator_signed,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [N_BITS-1:0]       rsp_quotient,
  output logic [N_BITS-1:0]       rsp_remainder,
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
  output logic                    timeout_err,
`endif
  output logic [N_BITS-1:0]       div_numerator,
  output logic [N_BITS-1:0]       div_denominator,
  output logic                    div_numerator_signed,
  output logic                    div_start,
  input  logic                    div_busy,
  input  logic [N_BITS-1:0]       div_quotient,
  input  logic [N_BITS-1:0]       div_remainder,
  input  logic                    div_result_valid
);

  localparam int PTR_W = ptr_width(N_REQ);

  state_t             state_reg;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   grant_reg;
  logic [N_REQ-1:0]   req_ack_reg;
  logic [N_REQ-1:0]   rsp_valid_reg;
  logic [N_BITS-1:0]  div_numerator_reg;
  logic [N_BITS-1:0]  div_denominator_reg;
  logic               div_numerator_signed_reg;
  logic [N_BITS-1:0]  rsp_quotient_reg;
  logic [N_BITS-1:0]  rsp_remainder_reg;

  logic               grant_valid;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [N_REQ-1:0]   ack_onehot;
  logic [N_REQ-1:0]   grant_onehot;
  logic [N_BITS-1:0]  num_arr [N_REQ];
  logic [N_BITS-1:0]  den_arr [N_REQ];

  // Split the packed operand buses into per-requester slices.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign num_arr[gi] = req_numerator[gi*N_BITS +: N_BITS];
    assign den_arr[gi] = req_denominator[gi*N_BITS +: N_BITS];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req         (req),
    .rr_ptr      (rr_ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign rr_ptr_next  = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  assign ack_onehot   = N_REQ'(1) << grant_idx;
  assign grant_onehot = N_REQ'(1) << grant_reg;

`ifdef DIVIDER_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_err_reg;
  logic             waiting;
  logic             timeout_hit;

  // A result arriving on the last allowed cycle still wins over the watchdog.
  assign waiting     = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_RESULT);
  assign timeout_hit = waiting && !(state_reg == ST_WAIT_RESULT && div_result_valid) &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_reg;

  // Watchdog counter: cleared while issuing, counts every waiting cycle.
  always_ff @(posedge clk) begin
    if (rst || state_reg == ST_ISSUE) begin
      wait_cnt_reg <= '0;
    end else if (waiting) begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end
`endif

  // Arbitration / divider handshake FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg                <= ST_IDLE;
      rr_ptr_reg               <= '0;
      grant_reg                <= '0;
      req_ack_reg              <= '0;
      rsp_valid_reg            <= '0;
      div_numerator_reg        <= '0;
      div_denominator_reg      <= '0;
      div_numerator_signed_reg <= 1'b0;
      rsp_quotient_reg         <= '0;
      rsp_remainder_reg        <= '0;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
      timeout_err_reg          <= 1'b0;
`endif
    end else begin
      req_ack_reg   <= '0;
      rsp_valid_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            grant_reg                <= grant_idx;
            rr_ptr_reg               <= rr_ptr_next;
            div_numerator_reg        <= num_arr[grant_idx];
            div_denominator_reg      <= den_arr[grant_idx];
            div_numerator_signed_reg <= req_numerator_signed[grant_idx];
            req_ack_reg              <= ack_onehot;
            state_reg                <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (div_busy) begin
            state_reg <= ST_WAIT_RESULT;
          end
        end
        ST_WAIT_RESULT: begin
          if (div_result_valid) begin
            rsp_quotient_reg  <= div_quotient;
            rsp_remainder_reg <= div_remainder;
            state_reg         <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          rsp_valid_reg <= grant_onehot;
          state_reg     <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
      // Divider never answered: abandon it and hand back the all-ones result.
      if (timeout_hit) begin
        rsp_valid_reg     <= grant_onehot;
        rsp_quotient_reg  <= TIMEOUT_RESULT[N_BITS-1:0];
        rsp_remainder_reg <= TIMEOUT_RESULT[N_BITS-1:0];
        timeout_err_reg   <= 1'b1;
        state_reg         <= ST_IDLE;
      end
`endif
    end
  end

  // Start is held from issue until the divider reports busy.
  assign div_start            = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_BUSY);
  assign req_ack              = req_ack_reg;
  assign rsp_valid            = rsp_valid_reg;
  assign rsp_quotient         = rsp_quotient_reg;
  assign rsp_remainder        = rsp_remainder_reg;
  assign div_numerator        = div_numerator_reg;
  assign div_denominator      = div_denominator_reg;
  assign div_numerator_signed = div_numerator_signed_reg;

endmodule
